icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_if.sv | 27 ++
 rtl/icache.sv | 124 ++++++++++++
 tb/tb_icache.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The slave modport is the cache; the master modport is its environment.
interface icache_if;
  logic        proc2Icache_req;
  logic [31:0] proc2Icache_addr;
  logic [63:0] Icache2proc_data;
  logic        Icache2proc_valid;
  logic [1:0]  Icache2ctrl_command;
  logic [31:0] Icache2ctrl_addr;
  logic [3:0]  ctrl2Icache_response;
  logic [63:0] ctrl2Icache_data;
  logic [3:0]  ctrl2Icache_tag;

  modport slave (
    input  proc2Icache_req, proc2Icache_addr,
    input  ctrl2Icache_response, ctrl2Icache_data, ctrl2Icache_tag,
    output Icache2proc_data, Icache2proc_valid,
    output Icache2ctrl_command, Icache2ctrl_addr
  );

  modport master (
    output proc2Icache_req, proc2Icache_addr,
    output ctrl2Icache_response, ctrl2Icache_data, ctrl2Icache_tag,
    input  Icache2proc_data, Icache2proc_valid,
    input  Icache2ctrl_command, Icache2ctrl_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, blocking instruction cache with one outstanding line miss.
// Hits are combinational; misses issue a tagged BUS_LOAD and fill on the matching tag.
module icache #(
  parameter int unsigned NUM_LINES  = 32,
  parameter int unsigned LINE_BYTES = 8
) (
  input  logic     clock,
  input  logic     reset_n,
  icache_if.slave  bus
);
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
  localparam int unsigned LINE_W = 32 - OFF_W;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                 state_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_W-1:0]       tags_q [NUM_LINES];
  logic [63:0]            data_q [NUM_LINES];
  logic [LINE_W-1:0]      miss_line_q;
  logic [3:0]             pend_tag_q;
  logic [1:0]             cmd_q;
  logic [31:0]            bus_addr_q;

  logic [IDX_W-1:0]       idx_s;
  logic [TAG_W-1:0]       tag_s;
  logic [LINE_W-1:0]      line_s;
  logic [IDX_W-1:0]       fill_idx_s;
  logic [TAG_W-1:0]       fill_tag_s;
  logic                   hit_s;
  logic                   fill_s;
  logic                   unused_offset_s;

  assign line_s          = bus.proc2Icache_addr[31:OFF_W];
  assign idx_s           = line_s[IDX_W-1:0];
  assign tag_s           = line_s[LINE_W-1:IDX_W];
  assign fill_idx_s      = miss_line_q[IDX_W-1:0];
  assign fill_tag_s      = miss_line_q[LINE_W-1:IDX_W];
  assign unused_offset_s = ^bus.proc2Icache_addr[OFF_W-1:0];

  // Lookup and fill qualification; a fill is not forwarded to the same-cycle lookup.
  always_comb begin
    hit_s  = 1'b0;
    fill_s = 1'b0;
    if (bus.proc2Icache_req && valid_q[idx_s] && (tags_q[idx_s] == tag_s)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
    if ((state_q == S_WAIT) && (bus.ctrl2Icache_tag != 4'd0) &&
        (bus.ctrl2Icache_tag == pend_tag_q)) begin
      fill_s = 1'b1;
    end else begin
      fill_s = 1'b0;
    end
  end

  assign bus.Icache2proc_valid   = hit_s;
  assign bus.Icache2proc_data    = hit_s ? data_q[idx_s] : 64'd0;
  assign bus.Icache2ctrl_command = cmd_q;
  assign bus.Icache2ctrl_addr    = bus_addr_q;

  // Miss FSM with registered bus outputs, plus the resettable valid bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      miss_line_q <= '0;
      pend_tag_q  <= 4'd0;
      cmd_q       <= BUS_NONE;
      bus_addr_q  <= 32'd0;
    end else begin
      if (fill_s) begin
        valid_q[fill_idx_s] <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.proc2Icache_req && !hit_s) begin
            state_q     <= S_REQ;
            miss_line_q <= line_s;
            cmd_q       <= BUS_LOAD;
            bus_addr_q  <= {line_s, {OFF_W{1'b0}}};
          end
        end
        S_REQ: begin
          // A zero response is a rejection; keep reissuing the same load.
          if (bus.ctrl2Icache_response != 4'd0) begin
            state_q    <= S_WAIT;
            pend_tag_q <= bus.ctrl2Icache_response;
            cmd_q      <= BUS_NONE;
            bus_addr_q <= 32'd0;
          end
        end
        S_WAIT: begin
          if (fill_s) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          cmd_q      <= BUS_NONE;
          bus_addr_q <= 32'd0;
        end
      endcase
    end
  end

  // Tag and data arrays are not reset; valid_q qualifies their contents.
  always_ff @(posedge clock) begin
    if (fill_s) begin
      tags_q[fill_idx_s] <= fill_tag_s;
      data_q[fill_idx_s] <= bus.ctrl2Icache_data;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed vector bench for icache: per-cycle table of inputs and expected outputs,
// followed by hand-written sequences for asynchronous reset and a bounded miss.
module tb_icache;
  logic clock;
  logic reset_n;

  icache_if bus ();

  icache #(.NUM_LINES(32), .LINE_BYTES(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] din;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic [1:0]  exp_cmd;
    logic [31:0] exp_baddr;
  } vec_t;

  localparam logic [63:0] D1   = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D2   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D3   = 64'h0800_0800_A5A5_5A5A;
  localparam logic [63:0] D4   = 64'h0040_0040_C3C3_3C3C;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic rst, input logic req, input logic [31:0] addr,
                     input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] din,
                     input logic ev, input logic [63:0] ed, input logic [1:0] ec,
                     input logic [31:0] eb);
    vec_t v;
    v.rst = rst; v.req = req; v.addr = addr; v.resp = resp; v.tag = tag; v.din = din;
    v.exp_valid = ev; v.exp_data = ed; v.exp_cmd = ec; v.exp_baddr = eb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tagname, input logic ev, input logic [63:0] ed,
                               input logic [1:0] ec, input logic [31:0] eb);
    check({tagname, " valid"}, {63'd0, bus.Icache2proc_valid}, {63'd0, ev});
    check({tagname, " data"},  bus.Icache2proc_data, ed);
    check({tagname, " cmd"},   {62'd0, bus.Icache2ctrl_command}, {62'd0, ec});
    check({tagname, " baddr"}, {32'd0, bus.Icache2ctrl_addr}, {32'd0, eb});
  endtask

  initial begin
    logic seen;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.proc2Icache_req      = 1'b0;
    bus.proc2Icache_addr     = 32'd0;
    bus.ctrl2Icache_response = 4'd0;
    bus.ctrl2Icache_tag      = 4'd0;
    bus.ctrl2Icache_data     = 64'd0;

    // rst req addr resp tag din | valid data cmd baddr
    // cold miss on 0x1004, accepted first REQ cycle, tag 3 three cycles later
    add(1'b1, 1'b1, 32'h1004, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1004, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1004, 4'd3, 4'd0, 64'd0, 1'b0, 64'd0, 2'd1, 32'h1000);
    add(1'b0, 1'b1, 32'h1004, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1004, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1004, 4'd0, 4'd3, D1,    1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1004, 4'd0, 4'd0, 64'd0, 1'b1, D1,    2'd0, 32'h0);
    // reset, then four rejections before response 5; foreign tags 2 and 7 ignored
    add(1'b1, 1'b1, 32'h1000, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1000, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      add(1'b0, 1'b1, 32'h1000, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd1, 32'h1000);
    end
    add(1'b0, 1'b1, 32'h1000, 4'd5, 4'd0, 64'd0, 1'b0, 64'd0, 2'd1, 32'h1000);
    add(1'b0, 1'b1, 32'h1000, 4'd0, 4'd2, JUNK,  1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1000, 4'd0, 4'd7, JUNK,  1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1000, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1000, 4'd0, 4'd5, D1,    1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1004, 4'd0, 4'd0, 64'd0, 1'b1, D1,    2'd0, 32'h0);
    // conflict 0x2000 on index 0; response and tag together in REQ; fetch moves during WAIT
    add(1'b0, 1'b1, 32'h2000, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h2000, 4'd4, 4'd4, JUNK,  1'b0, 64'd0, 2'd1, 32'h2000);
    add(1'b0, 1'b1, 32'h1000, 4'd0, 4'd0, 64'd0, 1'b1, D1,    2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1000, 4'd0, 4'd4, D2,    1'b1, D1,    2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h2000, 4'd0, 4'd0, 64'd0, 1'b1, D2,    2'd0, 32'h0);
    add(1'b0, 1'b0, 32'h2000, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    // fill 0x0800 (index 0); 0x1000 now misses; miss in the return-to-IDLE cycle
    add(1'b0, 1'b1, 32'h0804, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1000, 4'd1, 4'd0, 64'd0, 1'b0, 64'd0, 2'd1, 32'h0800);
    add(1'b0, 1'b1, 32'h1000, 4'd0, 4'd1, D3,    1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1000, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    // hits on 0x0800 during the 0x1000 miss, then reset mid-WAIT with pending tag 6
    add(1'b0, 1'b1, 32'h0800, 4'd6, 4'd0, 64'd0, 1'b1, D3,    2'd1, 32'h1000);
    add(1'b0, 1'b1, 32'h0800, 4'd0, 4'd0, 64'd0, 1'b1, D3,    2'd0, 32'h0);
    add(1'b1, 1'b1, 32'h0800, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b0, 32'h1000, 4'd0, 4'd6, D1,    1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h1000, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd0, 32'h0);
    add(1'b0, 1'b1, 32'h0800, 4'd0, 4'd0, 64'd0, 1'b0, 64'd0, 2'd1, 32'h1000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset_n                  = ~vecs[i].rst;
      bus.proc2Icache_req      = vecs[i].req;
      bus.proc2Icache_addr     = vecs[i].addr;
      bus.ctrl2Icache_response = vecs[i].resp;
      bus.ctrl2Icache_tag      = vecs[i].tag;
      bus.ctrl2Icache_data     = vecs[i].din;
      #1;
      check_outputs($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                    vecs[i].exp_cmd, vecs[i].exp_baddr);
    end

    // Asynchronous reset while in REQ clears the bus command before any clock edge.
    @(negedge clock);
    bus.proc2Icache_req      = 1'b0;
    bus.ctrl2Icache_response = 4'd0;
    bus.ctrl2Icache_tag      = 4'd0;
    bus.ctrl2Icache_data     = 64'd0;
    #1;
    check("async_pre cmd", {62'd0, bus.Icache2ctrl_command}, 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, 64'd0, 2'd0, 32'h0);

    // Bounded miss on index 8 after reset release, then hit on the filled line.
    @(negedge clock);
    reset_n              = 1'b1;
    bus.proc2Icache_req  = 1'b1;
    bus.proc2Icache_addr = 32'h0000_0044;
    #1;
    check("seq_miss valid", {63'd0, bus.Icache2proc_valid}, 64'd0);
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clock);
      #1;
      if (bus.Icache2ctrl_command == 2'd1) begin
        seen = 1'b1;
      end
    end
    check("seq_load_seen", {63'd0, seen}, 64'd1);
    check("seq_baddr", {32'd0, bus.Icache2ctrl_addr}, 64'h40);
    bus.ctrl2Icache_response = 4'd9;
    @(negedge clock);
    bus.ctrl2Icache_response = 4'd0;
    bus.ctrl2Icache_tag      = 4'd9;
    bus.ctrl2Icache_data     = D4;
    #1;
    check_outputs("seq_fill", 1'b0, 64'd0, 2'd0, 32'h0);
    @(negedge clock);
    bus.ctrl2Icache_tag  = 4'd0;
    bus.ctrl2Icache_data = 64'd0;
    #1;
    check_outputs("seq_hit", 1'b1, D4, 2'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
